bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/weakcore_pkg.sv | 24 ++
 rtl/bus_arb_timer.sv | 28 ++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/weakcore_pkg.sv
// rtl/weakcore_pkg.sv - shared arbiter state encoding and bus constants
// Contents: arbiter FSM state type, master index constants, bus width,
// and a helper that decodes a state into its one-hot grant vector.
package weakcore_pkg;

    localparam int BUS_W = 32;
    localparam int M0    = 0;
    localparam int M1    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_t;

    function automatic logic [1:0] gnt_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == ST_GNT0) g[M0] = 1'b1;
        if (s == ST_GNT1) g[M1] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/bus_arb_timer.sv
// rtl/bus_arb_timer.sv - 8-bit granted-cycle counter for slave timeout
// Ports: clk, rst (async, active-high); clear (priority over enable);
// enable (count one stalled cycle); threshold (compare value);
// expire (count equals threshold, combinational).
module bus_arb_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] threshold,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == threshold);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with slave timeout
// Ports: clk, rst (async, active-high); m0_*/m1_* master request side
// (req, wr, addr, out in; in, ack, err out); bus_* slave side
// (req, wr, addr, out out; in, ack in); gnt one-hot registered grant.
module bus_arbiter
    import weakcore_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_wr,
    input  logic [BUS_W-1:0] m0_addr,
    input  logic [BUS_W-1:0] m0_out,
    output logic [BUS_W-1:0] m0_in,
    output logic             m0_ack,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_wr,
    input  logic [BUS_W-1:0] m1_addr,
    input  logic [BUS_W-1:0] m1_out,
    output logic [BUS_W-1:0] m1_in,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             bus_req,
    output logic             bus_wr,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_out,
    input  logic [BUS_W-1:0] bus_in,
    input  logic             bus_ack,
    output logic [1:0]       gnt
);

    localparam logic [7:0] THRESH = 8'(TIMEOUT - 1);

    arb_state_t state, state_next;
    logic       ptr, ptr_next;
    logic [1:0] gnt_q;
    logic       armed;

    logic g0, g1;
    logic cur_req;
    logic expire;
    logic tmo;
    logic xfer_done;

    assign g0 = gnt_q[M0];
    assign g1 = gnt_q[M1];
    assign gnt = gnt_q;

    // cur_req already implies a grant is held.
    assign cur_req   = (g0 & m0_req) | (g1 & m1_req);
    assign tmo       = cur_req & ~bus_ack & expire;
    assign xfer_done = cur_req & (bus_ack | expire);

    // Cleared while idle (so every grant entry starts from zero), on abort
    // and on every completion or termination.
    bus_arb_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (~cur_req | xfer_done),
        .enable    (cur_req & ~bus_ack),
        .threshold (THRESH),
        .expire    (expire)
    );

    // armed holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt_q <= 2'b00;
            ptr   <= 1'b0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            gnt_q <= gnt_of(state_next);
            ptr   <= ptr_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        unique case (state)
            ST_IDLE: begin
                if (armed) begin
                    if (m0_req && m1_req) begin
                        state_next = ptr ? ST_GNT1 : ST_GNT0;
                    end else if (m0_req) begin
                        state_next = ST_GNT0;
                    end else if (m1_req) begin
                        state_next = ST_GNT1;
                    end
                end
            end
            ST_GNT0: begin
                if (!m0_req) begin
                    state_next = ST_IDLE;
                end else if (xfer_done) begin
                    ptr_next   = 1'b1;
                    state_next = m1_req ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!m1_req) begin
                    state_next = ST_IDLE;
                end else if (xfer_done) begin
                    ptr_next   = 1'b0;
                    state_next = m0_req ? ST_GNT0 : ST_GNT1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Slave side: AND-masked by the grant so nothing stale leaks while idle.
    assign bus_req  = cur_req & ~tmo;
    assign bus_wr   = (g0 & m0_wr) | (g1 & m1_wr);
    assign bus_addr = ({BUS_W{g0}} & m0_addr) | ({BUS_W{g1}} & m1_addr);
    assign bus_out  = ({BUS_W{g0}} & m0_out)  | ({BUS_W{g1}} & m1_out);

    // Master side: a timeout termination completes with err and zero data.
    assign m0_ack = g0 & xfer_done;
    assign m1_ack = g1 & xfer_done;
    assign m0_err = g0 & tmo;
    assign m1_err = g1 & tmo;
    assign m0_in  = {BUS_W{g0 & ~tmo}} & bus_in;
    assign m1_in  = {BUS_W{g1 & ~tmo}} & bus_in;

endmodule
